pe_vcounter: RTL and testbench
==============================

# pe_vcounter

Output-stationary processing element (PE) for a DIMENSION×DIMENSION systolic matrix multiplier. Each cycle it forwards its A operand east and its B operand south through one register stage. After a position-dependent skew of COUNTER_LIMIT cycles, it multiply-accumulates exactly DIMENSION operand pairs into a full-precision result, then raises a sticky finish flag. One instance sits at each array cell; COUNTER_LIMIT is the cell's diagonal skew (row + column index).

## Interface
- COUNTER_LIMIT, default 0: cycles after reset release that are ignored before accumulation starts; ≥ 0.
- DIMENSION, default 4: number of products accumulated (matrix size); ≥ 1.
- I_BITS, default 8: operand width, unsigned.
- O_BITS, default (2·I_BITS)+$clog2(DIMENSION): result width. Must be ≥ that value; the accumulator never overflows.
- i_clock  in  1  single clock, rising-edge.
- i_reset  in  1  reset; synchronous and active-high.
- i_a  in  I_BITS  A operand from west neighbour.
- i_b  in  I_BITS  B operand from north neighbour.
- o_a  out  I_BITS  registered copy of i_a, to east neighbour.
- o_b  out  I_BITS  registered copy of i_b, to south neighbour.
- o_c  out  O_BITS  accumulator value; final result when o_finish=1.
- o_finish  out  1  result valid, sticky until reset.

## Operation
- Operands are unsigned integers (fixed-point scaling is the caller's concern). Product width is 2·I_BITS, zero-extended to O_BITS; no rounding or truncation.
- State machine:
  - WAIT: counts reset-released edges up to COUNTER_LIMIT.
  - ACCUM: counts DIMENSION edges, each adding i_a·i_b to the accumulator.
  - DONE: holds.
- Entry from reset: WAIT if COUNTER_LIMIT>0, otherwise directly ACCUM.
- WAIT→ACCUM after COUNTER_LIMIT edges.
- ACCUM→DONE on the edge that adds the DIMENSION-th product.
- In DONE, accumulator and o_finish hold regardless of i_a/i_b. The counter saturates and never wraps.
- o_a/o_b forwarding is independent of state and runs in every state, including DONE.
- Reset (synchronous, at any time, including mid-ACCUM or in DONE) forces:
  - o_a=0, o_b=0, o_c=0, o_finish=0;
  - counter=0;
  - state = WAIT (or ACCUM when COUNTER_LIMIT=0).
- Inputs sampled on a reset edge are neither forwarded nor accumulated.

## Timing
- Edge k = k-th rising edge with i_reset=0, counting from k=0.
- Forwarding latency is 1 cycle: o_a/o_b after edge k equal i_a/i_b sampled at edge k.
- Accumulation: the pairs sampled at edges k = COUNTER_LIMIT … COUNTER_LIMIT+DIMENSION−1 are summed.
- o_c updates after each of those edges, so running partial sums are visible.
- o_finish rises immediately after edge COUNTER_LIMIT+DIMENSION−1. At that point o_c already holds the complete sum; no extra cycle.
- Total latency from reset release to o_finish: COUNTER_LIMIT+DIMENSION cycles.
- No handshake or backpressure; the upstream array must present data every cycle in skewed order.

## Structure
- Shared package holds:
  - the state enum (WAIT/ACCUM/DONE);
  - a width function for the counter: $clog2(COUNTER_LIMIT+DIMENSION+1);
  - the default O_BITS expression.
- One natural sub-module, pe_mac: combinational unsigned I_BITS×I_BITS multiply plus O_BITS accumulator register with clear and enable.
- pe_vcounter holds the operand pipeline registers, the counter and the FSM.

## Test plan
All scenarios use DIMENSION=4, I_BITS=8, O_BITS=18.
- Basic MAC, COUNTER_LIMIT=0: reset for 2 cycles, then (a,b)=(1,1),(2,2),(3,3),(4,4) on edges 0–3.
  - o_c=30 and o_finish=1 after edge 3.
  - o_finish=0 after edges 0–2.
  - o_c holds 30 while subsequent inputs (5,5) are applied.
- Forwarding: any input sequence gives o_a/o_b equal to the previous cycle's i_a/i_b, including in DONE.
  - Both outputs read 0 on the cycle after a reset edge.
- Skew, COUNTER_LIMIT=2: inputs (9,9),(9,9),(1,2),(3,4),(5,6),(7,8).
  - o_c stays 0 through edge 1.
  - Final o_c=2+12+30+56=100 with o_finish=1 after edge 5.
- Max range: a=b=255 for 4 pairs.
  - o_c=260100 (fits 18 bits), no wrap.
- Reset mid-operation: assert i_reset after edge 2 of the basic MAC sequence.
  - o_c=0 and o_finish=0 on the next cycle.
  - Re-running (1,1)…(4,4) yields 30 again after 4 edges.
- Reset in DONE: all outputs clear within 1 cycle, and a new accumulation proceeds normally.

Source files
------------

// File: rtl/pe_vcounter_pkg.sv
// pe_vcounter_pkg
//   Shared definitions for the systolic processing element:
//   - pe_state_e      : WAIT / ACCUM / DONE state encoding
//   - counter_width() : bits needed to count skew plus accumulation edges
//   - default_o_bits(): full-precision result width for DIMENSION products
package pe_vcounter_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } pe_state_e;

  // The counter has to reach COUNTER_LIMIT+DIMENSION and then sit there.
  function automatic int counter_width(input int limit, input int dimension);
    return $clog2(limit + dimension + 1);
  endfunction

  // Sum of DIMENSION products of two I_BITS operands never overflows this.
  function automatic int default_o_bits(input int i_bits, input int dimension);
    return (2 * i_bits) + $clog2(dimension);
  endfunction

endpackage

// File: rtl/pe_vcounter_if.sv
// pe_vcounter_if
//   Operand / result bundle of one PE.
//   i_a, i_b          : operands from the west / north neighbours
//   o_a, o_b          : registered operands towards east / south
//   o_c               : accumulator (final result once o_finish is high)
//   o_finish          : sticky result-valid flag
//   modport slave  : the PE side
//   modport master : the array / testbench side
interface pe_vcounter_if
  import pe_vcounter_pkg::*;
#(
  parameter int I_BITS    = 8,
  parameter int DIMENSION = 4,
  parameter int O_BITS    = default_o_bits(I_BITS, DIMENSION)
);

  logic [I_BITS-1:0] i_a;
  logic [I_BITS-1:0] i_b;
  logic [I_BITS-1:0] o_a;
  logic [I_BITS-1:0] o_b;
  logic [O_BITS-1:0] o_c;
  logic              o_finish;

  modport slave (
    input  i_a, i_b,
    output o_a, o_b, o_c, o_finish
  );

  modport master (
    output i_a, i_b,
    input  o_a, o_b, o_c, o_finish
  );

endinterface

// File: rtl/pe_mac.sv
// pe_mac
//   Unsigned I_BITS x I_BITS multiplier feeding an O_BITS accumulator.
//   i_clock  : rising-edge clock
//   i_clear  : synchronous clear of the accumulator (wins over i_enable)
//   i_enable : add i_a*i_b on this edge
//   i_a, i_b : unsigned operands
//   o_acc    : accumulator register
module pe_mac #(
  parameter int I_BITS = 8,
  parameter int O_BITS = 18
) (
  input  logic              i_clock,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic [I_BITS-1:0] i_a,
  input  logic [I_BITS-1:0] i_b,
  output logic [O_BITS-1:0] o_acc
);

  logic [2*I_BITS-1:0] product;
  logic [O_BITS-1:0]   acc;

  // Widen before multiplying so the full 2*I_BITS product is kept.
  assign product = (2*I_BITS)'(i_a) * (2*I_BITS)'(i_b);

  // Product is zero-extended; O_BITS is sized so the sum cannot wrap.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      acc <= '0;
    end else if (i_enable) begin
      acc <= acc + O_BITS'(product);
    end
  end

  assign o_acc = acc;

endmodule

// File: rtl/pe_vcounter.sv
// pe_vcounter
//   Output-stationary PE of a DIMENSION x DIMENSION systolic multiplier.
//   Forwards operands east/south through one register stage every cycle,
//   skips the first COUNTER_LIMIT edges after reset (diagonal skew), then
//   accumulates DIMENSION products and raises a sticky finish flag.
//   i_clock : rising-edge clock
//   i_reset : synchronous, active-high reset
//   bus     : operand / result bundle (pe_vcounter_if.slave)
module pe_vcounter
  import pe_vcounter_pkg::*;
#(
  parameter int COUNTER_LIMIT = 0,
  parameter int DIMENSION     = 4,
  parameter int I_BITS        = 8,
  parameter int O_BITS        = default_o_bits(I_BITS, DIMENSION)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  pe_vcounter_if.slave  bus
);

  localparam int CNT_W = counter_width(COUNTER_LIMIT, DIMENSION);

  localparam logic [1:0] S_WAIT  = 2'(ST_WAIT);
  localparam logic [1:0] S_ACCUM = 2'(ST_ACCUM);
  localparam logic [1:0] S_DONE  = 2'(ST_DONE);

  // With no skew the cell starts accumulating on the very first edge.
  localparam logic [1:0] S_START = (COUNTER_LIMIT > 0) ? S_WAIT : S_ACCUM;

  // Edge indices (counted from reset release) that end each phase.
  // LAST_WAIT is only meaningful when COUNTER_LIMIT > 0.
  localparam logic [CNT_W-1:0] LAST_WAIT  =
    CNT_W'((COUNTER_LIMIT > 0) ? (COUNTER_LIMIT - 1) : 0);
  localparam logic [CNT_W-1:0] LAST_ACCUM =
    CNT_W'(COUNTER_LIMIT + DIMENSION - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic [I_BITS-1:0] a_q;
  logic [I_BITS-1:0] b_q;
  logic [O_BITS-1:0] acc;
  logic              mac_enable;

  // Operand pipeline, counter and FSM. The counter is a single edge count
  // since reset release; it stops in DONE, so it saturates at
  // COUNTER_LIMIT+DIMENSION and never wraps. Forwarding runs in all states.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= S_START;
      count <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      a_q <= bus.i_a;
      b_q <= bus.i_b;
      case (state)
        S_WAIT: begin
          count <= count + CNT_W'(1);
          if (count == LAST_WAIT) begin
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          count <= count + CNT_W'(1);
          if (count == LAST_ACCUM) begin
            state <= S_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Only the ACCUM edges add a product; DONE freezes the accumulator.
  assign mac_enable = (state == S_ACCUM);

  pe_mac #(
    .I_BITS (I_BITS),
    .O_BITS (O_BITS)
  ) u_mac (
    .i_clock  (i_clock),
    .i_clear  (i_reset),
    .i_enable (mac_enable),
    .i_a      (bus.i_a),
    .i_b      (bus.i_b),
    .o_acc    (acc)
  );

  // Entering DONE coincides with the last product landing in acc, so the
  // flag and the complete sum become visible together.
  assign bus.o_a      = a_q;
  assign bus.o_b      = b_q;
  assign bus.o_c      = acc;
  assign bus.o_finish = (state == S_DONE);

endmodule

// File: tb/tb_pe_vcounter.sv
// tb_pe_vcounter
//   Drives two PEs (skew 0 and skew 2, DIMENSION=4, 8-bit operands, 18-bit
//   result) with the same operand/reset stream. A behavioural model counts
//   edges since reset release and sums products in the accumulation window;
//   every cycle both PEs are compared against it, and a set of hand-computed
//   values pins the model at the directed scenario points.
module tb_pe_vcounter;

  localparam int DIM  = 4;
  localparam int IW   = 8;
  localparam int OW   = 18;
  localparam int LIM0 = 0;
  localparam int LIM1 = 2;

  logic          clk;
  logic          rst;
  logic [IW-1:0] ia;
  logic [IW-1:0] ib;

  int checkCount = 0;
  int failCount  = 0;
  bit checkEnable = 0;

  // Behavioural model state, index 0 = skew 0 cell, index 1 = skew 2 cell.
  int    lim  [2] = '{LIM0, LIM1};
  int    mK   [2] = '{0, 0};
  longint mSum[2] = '{0, 0};
  longint mA  [2] = '{0, 0};
  longint mB  [2] = '{0, 0};

  pe_vcounter_if #(.I_BITS(IW), .DIMENSION(DIM), .O_BITS(OW)) busA ();
  pe_vcounter_if #(.I_BITS(IW), .DIMENSION(DIM), .O_BITS(OW)) busB ();

  assign busA.i_a = ia;
  assign busA.i_b = ib;
  assign busB.i_a = ia;
  assign busB.i_b = ib;

  pe_vcounter #(
    .COUNTER_LIMIT (LIM0),
    .DIMENSION     (DIM),
    .I_BITS        (IW),
    .O_BITS        (OW)
  ) dutA (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (busA.slave)
  );

  pe_vcounter #(
    .COUNTER_LIMIT (LIM1),
    .DIMENSION     (DIM),
    .I_BITS        (IW),
    .O_BITS        (OW)
  ) dutB (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: edge k since reset release, products of edges
  // lim..lim+DIM-1 are summed, finish once k has reached lim+DIM.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mK[i]   = 0;
        mSum[i] = 0;
        mA[i]   = 0;
        mB[i]   = 0;
      end else begin
        mA[i] = longint'(ia);
        mB[i] = longint'(ib);
        if (mK[i] >= lim[i] && mK[i] < lim[i] + DIM)
          mSum[i] = mSum[i] + longint'(ia) * longint'(ib);
        if (mK[i] < lim[i] + DIM)
          mK[i] = mK[i] + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("A.o_a",      longint'(busA.o_a),      mA[0]);
      checkOutput("A.o_b",      longint'(busA.o_b),      mB[0]);
      checkOutput("A.o_c",      longint'(busA.o_c),      mSum[0]);
      checkOutput("A.o_finish", longint'(busA.o_finish), longint'(mK[0] >= lim[0] + DIM));
      checkOutput("B.o_a",      longint'(busB.o_a),      mA[1]);
      checkOutput("B.o_b",      longint'(busB.o_b),      mB[1]);
      checkOutput("B.o_c",      longint'(busB.o_c),      mSum[1]);
      checkOutput("B.o_finish", longint'(busB.o_finish), longint'(mK[1] >= lim[1] + DIM));
    end
  end

  // Present one operand pair (and reset level) for the next rising edge,
  // returning on the following falling edge when outputs are settled.
  task automatic applyStimulus(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic r);
    #1;
    ia  = a;
    ib  = b;
    rst = r;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ia  = '0;
    ib  = '0;

    $display("[TB] reset");
    applyStimulus(8'd0, 8'd0, 1'b1);
    applyStimulus(8'd0, 8'd0, 1'b1);
    checkEnable = 1;
    checkOutput("reset A.o_a",      longint'(busA.o_a), 0);
    checkOutput("reset A.o_b",      longint'(busA.o_b), 0);
    checkOutput("reset A.o_c",      longint'(busA.o_c), 0);
    checkOutput("reset A.o_finish", longint'(busA.o_finish), 0);

    $display("[TB] basic MAC");
    applyStimulus(8'd1, 8'd1, 1'b0);
    checkOutput("basic finish e0", longint'(busA.o_finish), 0);
    applyStimulus(8'd2, 8'd2, 1'b0);
    checkOutput("basic finish e1", longint'(busA.o_finish), 0);
    applyStimulus(8'd3, 8'd3, 1'b0);
    checkOutput("basic finish e2", longint'(busA.o_finish), 0);
    applyStimulus(8'd4, 8'd4, 1'b0);
    checkOutput("basic o_c e3",    longint'(busA.o_c), 30);
    checkOutput("basic finish e3", longint'(busA.o_finish), 1);
    checkOutput("model A sum e3",  mSum[0], 30);
    applyStimulus(8'd5, 8'd5, 1'b0);
    applyStimulus(8'd5, 8'd5, 1'b0);
    checkOutput("done hold o_c",   longint'(busA.o_c), 30);
    checkOutput("done fwd o_a",    longint'(busA.o_a), 5);
    checkOutput("skew2 o_c",       longint'(busB.o_c), 75);
    checkOutput("skew2 finish",    longint'(busB.o_finish), 1);
    checkOutput("model B sum",     mSum[1], 75);

    $display("[TB] reset mid-accumulation");
    applyStimulus(8'd0, 8'd0, 1'b1);
    applyStimulus(8'd1, 8'd1, 1'b0);
    applyStimulus(8'd2, 8'd2, 1'b0);
    applyStimulus(8'd3, 8'd3, 1'b0);
    checkOutput("mid partial o_c", longint'(busA.o_c), 14);
    applyStimulus(8'd7, 8'd7, 1'b1);
    checkOutput("mid rst o_c",      longint'(busA.o_c), 0);
    checkOutput("mid rst o_finish", longint'(busA.o_finish), 0);
    checkOutput("mid rst o_a",      longint'(busA.o_a), 0);
    applyStimulus(8'd1, 8'd1, 1'b0);
    applyStimulus(8'd2, 8'd2, 1'b0);
    applyStimulus(8'd3, 8'd3, 1'b0);
    applyStimulus(8'd4, 8'd4, 1'b0);
    checkOutput("rerun o_c",      longint'(busA.o_c), 30);
    checkOutput("rerun o_finish", longint'(busA.o_finish), 1);

    $display("[TB] reset in DONE, then skew sequence");
    applyStimulus(8'd6, 8'd6, 1'b1);
    checkOutput("done rst A.o_c",      longint'(busA.o_c), 0);
    checkOutput("done rst A.o_finish", longint'(busA.o_finish), 0);
    checkOutput("done rst B.o_b",      longint'(busB.o_b), 0);
    applyStimulus(8'd9, 8'd9, 1'b0);
    applyStimulus(8'd9, 8'd9, 1'b0);
    checkOutput("skew B o_c e1",   longint'(busB.o_c), 0);
    applyStimulus(8'd1, 8'd2, 1'b0);
    applyStimulus(8'd3, 8'd4, 1'b0);
    applyStimulus(8'd5, 8'd6, 1'b0);
    checkOutput("skew B finish e4", longint'(busB.o_finish), 0);
    applyStimulus(8'd7, 8'd8, 1'b0);
    checkOutput("skew B o_c e5",    longint'(busB.o_c), 100);
    checkOutput("skew B finish e5", longint'(busB.o_finish), 1);
    checkOutput("skew A o_c",       longint'(busA.o_c), 176);
    checkOutput("model B skew",     mSum[1], 100);

    $display("[TB] max range");
    applyStimulus(8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(8'd255, 8'd255, 1'b0);
    checkOutput("max A o_c", longint'(busA.o_c), 260100);
    checkOutput("max B o_c", longint'(busB.o_c), 260100);
    checkOutput("max B finish", longint'(busB.o_finish), 1);

    $display("[TB] random stream");
    for (int i = 0; i < 400; i++) begin
      logic [IW-1:0] ra;
      logic [IW-1:0] rb;
      logic          rr;
      ra = ($urandom_range(0, 9) == 0) ? 8'd255 : IW'($urandom_range(0, 255));
      rb = ($urandom_range(0, 9) == 0) ? 8'd255 : IW'($urandom_range(0, 255));
      rr = ($urandom_range(0, 99) < 4);
      applyStimulus(ra, rb, rr);
    end

    checkEnable = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
